seq_div_unit: RTL and testbench
===============================

SEQ_DIV_UNIT -- requirements
Module: seq_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; all values below assume 32.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  dividend, captured when start is accepted.
REQ-006 SHALL have port B  input  WIDTH  divisor, captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high in CALC.
REQ-008 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-009 SHALL have port quotient  output  WIDTH  result quotient, held until next accepted start.
REQ-010 SHALL have port remainder  output  WIDTH  result remainder, held likewise.
REQ-011 SHALL have port div_zero  output  1  divisor was zero, held with results.
REQ-012 SHALL have port overflow  output  1  signed overflow, held with results; 0 when SIGNED_DIV_EN is undefined.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE: IDLE->CALC on start with B!=0; IDLE->DONE on start with B==0; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-014 SHALL perform restoring division, one quotient bit per CALC cycle: shift partial remainder left with next dividend bit, subtract divisor via WIDTH+1-bit subtractor, keep difference and set quotient bit 1 if no borrow, else restore and set 0.
REQ-015 SHALL assert done for exactly one cycle, start edge at cycle T -> done high in cycle T+33 (B!=0) or T+1 (B==0).
REQ-016 SHALL update quotient/remainder/div_zero/overflow only on entry to DONE; held stable otherwise.
REQ-017 SHALL ignore start while in CALC or DONE; start in the IDLE cycle after DONE is accepted (back-to-back).
REQ-018 SHALL on B==0 return quotient=0xFFFFFFFF, remainder=A, div_zero=1, no CALC cycles.
REQ-019 SHALL guarantee remainder < divisor (magnitude) and A == quotient*B + remainder for all non-zero B.
REQ-020 SHALL clear div_zero and overflow on every accepted start with valid result.

Reset
REQ-021 SHALL on reset (any state, including mid-CALC) enter IDLE and drive busy=0, done=0, quotient=0, remainder=0, div_zero=0, overflow=0 on the next cycle.
REQ-022 SHALL discard any in-flight operation on reset; no done pulse for it.

Configuration
REQ-023 SHALL with macro SIGNED_DIV_EN defined treat A,B as two's complement: divide magnitudes, negate quotient if signs differ, remainder takes sign of A, latency unchanged.
REQ-024 SHALL with SIGNED_DIV_EN defined return for A=0x80000000,B=0xFFFFFFFF quotient=0x80000000, remainder=0, overflow=1.
REQ-025 SHALL with SIGNED_DIV_EN undefined treat operands as unsigned, omit sign logic, tie overflow to 0.

Structure
REQ-026 SHALL place state encoding (IDLE/CALC/DONE), WIDTH default, and iteration-count constant in shared package div_pkg.
REQ-027 SHALL instantiate one sub-module sub_A_B: combinational WIDTH+1-bit ripple subtractor (A + ~B + 1) built from existing full_adder cells, outputs difference and borrow.

Verification
REQ-028 SHALL cover A=100,B=7, start at T -> busy T+1..T+32, done at T+33, quotient=14, remainder=2.
REQ-029 SHALL cover A=5,B=0 -> done at T+1, quotient=0xFFFFFFFF, remainder=5, div_zero=1.
REQ-030 SHALL cover A=0xFFFFFF9C,B=7 -> signed: quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; unsigned: quotient=0x24924916, remainder=2.
REQ-031 SHALL cover signed A=0x80000000,B=0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1.
REQ-032 SHALL cover reset at T+10 of an operation -> IDLE, all outputs 0, no done; then new start A=9,B=3 -> quotient=3, remainder=0.
REQ-033 SHALL cover start held high through CALC -> ignored; re-accepted in IDLE cycle after done, second result correct.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    // One quotient bit is resolved per CALC cycle.
    localparam int ITER_COUNT = DIV_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build ripple arithmetic.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/sub_A_B.sv
// Combinational N-bit ripple subtractor a - b computed as a + ~b + 1 from full_adder cells.
module sub_A_B #(
    parameter int N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (~b_i[i]),
            .c_i (carry[i]),
            .s_o (diff_o[i]),
            .c_o (carry[i+1])
        );
    end

    // No carry out of the top bit means a < b.
    assign borrow_o = ~carry[N];

endmodule

// File: rtl/seq_div_unit.sv
// Sequential restoring divider, one quotient bit per cycle.
// Optional macro SIGNED_DIV_EN selects two's-complement operands; default is unsigned.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; operands captured on acceptance
// ST_CALC | WIDTH restoring iterations, busy high
// ST_DONE | one-cycle done pulse; results were registered on entry
module seq_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             unused_diff_msb;
    logic [WIDTH-1:0] step_rem, step_dvd;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] fin_quo, fin_rem;

`ifdef SIGNED_DIV_EN
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic a_neg, b_neg, op_ovf;
    logic rneg_q, rneg_d;
    logic qneg_q, qneg_d;
    logic oflag_q, oflag_d;

    assign a_neg  = A[WIDTH-1];
    assign b_neg  = B[WIDTH-1];
    assign a_mag  = a_neg ? (~A + ONE) : A;
    assign b_mag  = b_neg ? (~B + ONE) : B;
    assign op_ovf = (A == MOST_NEG) && (&B);

    assign fin_quo = qneg_q ? (~step_dvd + ONE) : step_dvd;
    assign fin_rem = rneg_q ? (~step_rem + ONE) : step_rem;
`else
    assign a_mag   = A;
    assign b_mag   = B;
    assign fin_quo = step_dvd;
    assign fin_rem = step_rem;
`endif

    // Partial remainder pulls in the next dividend bit; quotient bits shift into dvd.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};

    sub_A_B #(.N(WIDTH + 1)) u_sub (
        .a_i      (shifted),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    assign unused_diff_msb = diff[WIDTH];
    assign step_rem = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign step_dvd = {dvd_q[WIDTH-2:0], ~borrow};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        res_rem_d = res_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
`ifdef SIGNED_DIV_EN
        rneg_d    = rneg_q;
        qneg_d    = qneg_q;
        oflag_d   = oflag_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (B == '0) begin
                        state_d   = ST_DONE;
                        quo_d     = '1;
                        res_rem_d = A;
                        dz_d      = 1'b1;
                        ovf_d     = 1'b0;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        rem_d   = '0;
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
`ifdef SIGNED_DIV_EN
                        rneg_d  = a_neg;
                        qneg_d  = a_neg ^ b_neg;
                        oflag_d = op_ovf;
`endif
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                if (cnt_q == '0) begin
                    state_d   = ST_DONE;
                    quo_d     = fin_quo;
                    res_rem_d = fin_rem;
                    dz_d      = 1'b0;
`ifdef SIGNED_DIV_EN
                    ovf_d     = oflag_q;
`else
                    ovf_d     = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            res_rem_q <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef SIGNED_DIV_EN
            rneg_q    <= 1'b0;
            qneg_q    <= 1'b0;
            oflag_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            res_rem_q <= res_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
`ifdef SIGNED_DIV_EN
            rneg_q    <= rneg_d;
            qneg_q    <= qneg_d;
            oflag_q   <= oflag_d;
`endif
        end
    end

    assign busy      = (state_q == ST_CALC);
    assign done      = (state_q == ST_DONE);
    assign quotient  = quo_q;
    assign remainder = res_rem_q;
    assign div_zero  = dz_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Scoreboard bench for seq_div_unit: directed vectors queue expected results, a monitor checks on done.
module tb_seq_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A, B;
    logic         busy, done, div_zero, overflow;
    logic [W-1:0] quotient, remainder;

    seq_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int busy_run = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
        int           done_cyc;
        int           busy_len;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending result", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("quotient",    quotient,  e.q);
                    chk("remainder",   remainder, e.r);
                    chk("div_zero",    {31'd0, div_zero}, {31'd0, e.dz});
                    chk("overflow",    {31'd0, overflow}, {31'd0, e.ovf});
                    chk("done_cycle",  cyc,      e.done_cyc);
                    chk("busy_cycles", busy_run, e.busy_len);
                    chk("done_pulse_width", {31'd0, prev_done}, 32'd0);
                end
                busy_run = 0;
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] qx, input logic [W-1:0] rx,
                         input logic dz, input logic ov, input bit push);
        exp_t e;
        int guard;
        guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got busy=%0b done=%0b expected idle", busy, done);
        end
        A     = a;
        B     = b;
        start = 1'b1;
        e.q        = qx;
        e.r        = rx;
        e.dz       = dz;
        e.ovf      = ov;
        e.done_cyc = cyc + ((b == '0) ? 1 : 33);
        e.busy_len = (b == '0) ? 0 : 32;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!done && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got done=0 expected done within 60 cycles");
        end
    endtask

    task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] qx, input logic [W-1:0] rx,
                           input logic dz, input logic ov);
        issue(a, b, qx, rx, dz, ov, 1'b1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",      {31'd0, busy},     32'd0);
        chk("rst_done",      {31'd0, done},     32'd0);
        chk("rst_quotient",  quotient,          32'd0);
        chk("rst_remainder", remainder,         32'd0);
        chk("rst_div_zero",  {31'd0, div_zero}, 32'd0);
        chk("rst_overflow",  {31'd0, overflow}, 32'd0);
        reset = 1'b0;

        run_vec(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        run_vec(32'd5,   32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
`ifdef SIGNED_DIV_EN
        run_vec(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_vec(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
`else
        run_vec(32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0, 1'b0);
        run_vec(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
`endif
        run_vec(32'd0,         32'd5,         32'd0,         32'd0,    1'b0, 1'b0);
        run_vec(32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,    1'b0, 1'b0);
        run_vec(32'd7,         32'd7,         32'd1,         32'd0,    1'b0, 1'b0);
        run_vec(32'd6,         32'd7,         32'd0,         32'd6,    1'b0, 1'b0);
        run_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,    1'b0, 1'b0);
        run_vec(32'h1234_5678, 32'h100,       32'h0012_3456, 32'h78,   1'b0, 1'b0);
        run_vec(32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0,    1'b1, 1'b0);

        // Reset ten cycles into an operation: discarded, outputs cleared, no done.
        issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy",      {31'd0, busy},     32'd0);
        chk("midrst_done",      {31'd0, done},     32'd0);
        chk("midrst_quotient",  quotient,          32'd0);
        chk("midrst_remainder", remainder,         32'd0);
        chk("midrst_div_zero",  {31'd0, div_zero}, 32'd0);
        chk("midrst_overflow",  {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_pending", sb.size(), 32'd0);
        run_vec(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

        // Start held high: ignored in CALC/DONE, re-accepted in the IDLE cycle after done.
        @(negedge clk);
        @(negedge clk);
        t0    = cyc;
        A     = 32'd20;
        B     = 32'd6;
        start = 1'b1;
        sb.push_back('{q: 32'd3,   r: 32'd2, dz: 1'b0, ovf: 1'b0, done_cyc: t0 + 33, busy_len: 32});
        sb.push_back('{q: 32'd100, r: 32'd0, dz: 1'b0, ovf: 1'b0, done_cyc: t0 + 67, busy_len: 32});
        repeat (3) @(negedge clk);
        A = 32'd1000;
        B = 32'd10;
        while (cyc < t0 + 35) @(negedge clk);
        start = 1'b0;
        wait_done();

        repeat (5) @(negedge clk);
        chk("pending_results", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
